alu_op_sequencer: RTL and testbench

- Initiator side of the combinational ALU. It owns the ALU's OP/InputA/InputB bus and consumes its Out/Zero/Parity/Odd results.
- It accepts an operation request through a valid/ready handshake. It then iterates that operation N times, feeding each ALU result back as the next InputA, so multiply-by-add and multi-bit shift sequences become single requests.
- It returns the final result and flags through a valid/ready response. It sits between the control unit and the ALU.

---
 rtl/alu_op_sequencer_pkg.sv | 37 +++
 rtl/alu_op_sequencer_if.sv | 46 ++++
 rtl/alu_iter_counter.sv | 28 ++
 rtl/alu_op_sequencer.sv | 105 ++++++++++
 tb/tb_alu_op_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: widths, FSM states,
// ALU opcode mnemonics and the result-flag payload.
package alu_op_sequencer_pkg;

  localparam int unsigned W   = 8;
  localparam int unsigned OPS = 3;
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  typedef enum logic [OPS-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLL = 3'd5,
    SRL = 3'd6,
    NOP = 3'd7
  } op_mne_t;

  typedef struct packed {
    logic zero;
    logic parity;
    logic odd;
  } alu_flags_t;

  // Ops whose result can never leave zero once it has reached zero.
  function automatic logic zero_sticky_op(input logic [OPS-1:0] op);
    return (op == AND) || (op == SLL);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake plus the ALU operand/result bus of the sequencer.
interface alu_op_sequencer_if;
  import alu_op_sequencer_pkg::*;

  logic           ReqValid;
  logic           ReqReady;
  logic [OPS-1:0] ReqOp;
  logic [W-1:0]   ReqA;
  logic [W-1:0]   ReqB;
  logic [CW-1:0]  ReqCount;

  logic [OPS-1:0] AluOP;
  logic [W-1:0]   AluA;
  logic [W-1:0]   AluB;
  logic [W-1:0]   AluOut;
  logic           AluZero;
  logic           AluParity;
  logic           AluOdd;

  logic           RspValid;
  logic           RspReady;
  logic [W-1:0]   RspData;
  logic           RspZero;
  logic           RspParity;
  logic           RspOdd;
  logic           Busy;

  // Sequencer view.
  modport slave (
    input  ReqValid, ReqOp, ReqA, ReqB, ReqCount,
    input  AluOut, AluZero, AluParity, AluOdd,
    input  RspReady,
    output ReqReady, AluOP, AluA, AluB,
    output RspValid, RspData, RspZero, RspParity, RspOdd, Busy
  );

  // Control unit + ALU view.
  modport master (
    output ReqValid, ReqOp, ReqA, ReqB, ReqCount,
    output AluOut, AluZero, AluParity, AluOdd,
    output RspReady,
    input  ReqReady, AluOP, AluA, AluB,
    input  RspValid, RspData, RspZero, RspParity, RspOdd, Busy
  );

endinterface

// File: rtl/alu_iter_counter.sv
// Loadable iteration down-counter; a load of 0 is remapped to 1 and
// last_c flags the final iteration (count == 1).
module alu_iter_counter
  import alu_op_sequencer_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          last_c
);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? CW'(1) : load_val;
    end else if (dec) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last_c = (cnt == CW'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Iterates one ALU operation N times, feeding Out back into InputA, and returns
// the final result and flags. Optional early exit: define ALU_SEQ_EARLY_EXIT_EN.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  alu_op_sequencer_if.slave   bus
);

  seq_state_t     state;
  logic [W-1:0]   acc;
  logic [W-1:0]   b_r;
  logic [OPS-1:0] op_r;
  alu_flags_t     flags_r;
  logic           req_ready_r;
  logic           rsp_valid_r;
  logic           busy_r;

  logic           accept_c;
  logic           exec_c;
  logic           cnt_last_c;
  logic           early_c;

  assign accept_c = (state == IDLE) && bus.ReqValid;
  assign exec_c   = (state == EXEC);

`ifdef ALU_SEQ_EARLY_EXIT_EN
  assign early_c = bus.AluZero && zero_sticky_op(op_r);
`else
  assign early_c = 1'b0;
`endif

  alu_iter_counter u_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (accept_c),
    .load_val (bus.ReqCount),
    .dec      (exec_c),
    .last_c   (cnt_last_c)
  );

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= IDLE;
      acc         <= '0;
      b_r         <= '0;
      op_r        <= '0;
      flags_r     <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            acc         <= bus.ReqA;
            b_r         <= bus.ReqB;
            op_r        <= bus.ReqOp;
            state       <= EXEC;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        EXEC: begin
          acc     <= bus.AluOut;
          flags_r <= alu_flags_t'{zero: bus.AluZero, parity: bus.AluParity, odd: bus.AluOdd};
          if (cnt_last_c || early_c) begin
            state       <= RESP;
            rsp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (bus.RspReady) begin
            state       <= IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // ALU bus is only driven while iterating.
  assign bus.AluOP = exec_c ? op_r : '0;
  assign bus.AluA  = exec_c ? acc  : '0;
  assign bus.AluB  = exec_c ? b_r  : '0;

  assign bus.ReqReady  = req_ready_r;
  assign bus.RspValid  = rsp_valid_r;
  assign bus.RspData   = acc;
  assign bus.RspZero   = flags_r.zero;
  assign bus.RspParity = flags_r.parity;
  assign bus.RspOdd    = flags_r.odd;
  assign bus.Busy      = busy_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU
// and an iterate-N-times reference model.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0] last_data;
  logic         last_zero, last_parity, last_odd;
  int           last_lat;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [OPS-1:0] op, input logic [W-1:0] a, b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SLL:     return a << b;
      SRL:     return a >> b;
      default: return '0;
    endcase
  endfunction

  // Behavioural combinational ALU.
  always_comb begin
    bus.AluOut    = alu_f(bus.AluOP, bus.AluA, bus.AluB);
    bus.AluZero   = (bus.AluOut == '0);
    bus.AluParity = ^bus.AluOut;
    bus.AluOdd    = bus.AluOut[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: apply the op N times to the accumulator, counting iterations.
  task automatic ref_model(input logic [OPS-1:0] op, input logic [W-1:0] a, b,
                           input logic [CW-1:0] cnt,
                           output logic [W-1:0] d, output logic z, p, o, output int n);
    int eff;
    eff = (cnt == 0) ? 1 : int'(cnt);
    d = a; z = 0; p = 0; o = 0; n = 0;
    for (int i = 0; i < eff; i++) begin
      d = alu_f(op, d, b);
      z = (d == 0); p = ^d; o = d[0];
      n = i + 1;
`ifdef ALU_SEQ_EARLY_EXIT_EN
      if (z && (op == AND || op == SLL)) break;
`endif
    end
  endtask

  task automatic do_req(input logic [OPS-1:0] op, input logic [W-1:0] a, b,
                        input logic [CW-1:0] cnt, input int hold);
    logic [W-1:0] ed;
    logic ez, ep, eo;
    int en, e;
    ref_model(op, a, b, cnt, ed, ez, ep, eo, en);
    @(negedge clk);
    check("req_ready_idle", 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = 1'b1; bus.ReqOp = op; bus.ReqA = a; bus.ReqB = b; bus.ReqCount = cnt;
    bus.RspReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.ReqValid = 1'b0;
    check("exec_busy", 32'(bus.Busy), 32'd1);
    check("exec_req_ready", 32'(bus.ReqReady), 32'd0);
    check("exec_alu_op", 32'(bus.AluOP), 32'(op));
    check("exec_alu_a", 32'(bus.AluA), 32'(a));
    check("exec_alu_b", 32'(bus.AluB), 32'(b));
    e = 0;
    while (!bus.RspValid && e < 40) begin
      @(negedge clk);
      e++;
    end
    check("latency", 32'(e + 1), 32'(en + 1));
    check("rsp_data", 32'(bus.RspData), 32'(ed));
    check("rsp_zero", 32'(bus.RspZero), 32'(ez));
    check("rsp_parity", 32'(bus.RspParity), 32'(ep));
    check("rsp_odd", 32'(bus.RspOdd), 32'(eo));
    last_data = bus.RspData; last_zero = bus.RspZero;
    last_parity = bus.RspParity; last_odd = bus.RspOdd; last_lat = e + 1;
    for (int i = 0; i < hold; i++) begin
      bus.ReqValid = 1'b1;
      bus.ReqOp = OPS'($urandom_range(0, 7));
      bus.ReqA  = W'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(bus.RspValid), 32'd1);
      check("hold_data", 32'(bus.RspData), 32'(ed));
      check("hold_flags", 32'({bus.RspZero, bus.RspParity, bus.RspOdd}), 32'({ez, ep, eo}));
      check("hold_req_ready", 32'(bus.ReqReady), 32'd0);
    end
    bus.ReqValid = 1'b0;
    bus.RspReady = 1'b1;
    @(negedge clk);
    bus.RspReady = 1'b0;
    check("post_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("post_busy", 32'(bus.Busy), 32'd0);
    check("post_req_ready", 32'(bus.ReqReady), 32'd1);
    check("post_alu_a", 32'(bus.AluA), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.ReqValid = 1'b0; bus.ReqOp = '0; bus.ReqA = '0; bus.ReqB = '0;
    bus.ReqCount = '0; bus.RspReady = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.ReqReady), 32'd1);
    check("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_rsp_data", 32'(bus.RspData), 32'd0);
    check("rst_alu_op", 32'(bus.AluOP), 32'd0);
    rst_n = 1'b1;

    do_req(ADD, 8'd3, 8'd5, 4'd4, 5);
    check("add_data", 32'(last_data), 32'd23);
    check("add_flags", 32'({last_zero, last_parity, last_odd}), 32'b001);
    check("add_latency", 32'(last_lat), 32'd5);

    do_req(SLL, 8'd1, 8'd1, 4'd3, 0);
    check("sll_data", 32'(last_data), 32'd8);
    check("sll_odd", 32'(last_odd), 32'd0);

    do_req(ADD, 8'd200, 8'd100, 4'd0, 1);
    check("cnt0_data", 32'(last_data), 32'd44);
    check("cnt0_flags", 32'({last_zero, last_parity, last_odd}), 32'b010);
    check("cnt0_latency", 32'(last_lat), 32'd2);

    do_req(AND, 8'hF0, 8'h0F, 4'd8, 0);
    check("and_data", 32'(last_data), 32'd0);
    check("and_zero", 32'(last_zero), 32'd1);
`ifdef ALU_SEQ_EARLY_EXIT_EN
    check("and_latency", 32'(last_lat), 32'd2);
`else
    check("and_latency", 32'(last_lat), 32'd9);
`endif

    // Reset in the 2nd EXEC cycle of a long ADD.
    @(negedge clk);
    bus.ReqValid = 1'b1; bus.ReqOp = ADD; bus.ReqA = 8'd7; bus.ReqB = 8'd9; bus.ReqCount = 4'd8;
    @(negedge clk);
    bus.ReqValid = 1'b0;
    @(negedge clk);
    check("mid_exec_busy", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(bus.Busy), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("mid_rst_alu_bus", 32'({bus.AluOP, bus.AluA, bus.AluB}), 32'd0);
    check("mid_rst_req_ready", 32'(bus.ReqReady), 32'd1);
    check("mid_rst_rsp_data", 32'(bus.RspData), 32'd0);
    do_req(ADD, 8'd10, 8'd20, 4'd2, 0);
    check("after_rst_data", 32'(last_data), 32'd50);

    for (int k = 0; k < 30; k++) begin
      do_req(OPS'($urandom_range(0, 7)), W'($urandom), W'($urandom_range(0, 9)),
             CW'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
